hazard_control_unit: RTL
========================

// Module: hazard_control_unit
// PURPOSE
//  Producer of pipeline stall/flush controls for the 5-stage MIPS pipeline; pairs with the EX-stage forwarding unit.
//  Covers only the hazards that bypassing cannot resolve:
//  - load-use in EX;
//  - branch operands resolved in ID;
//  - multi-cycle data-memory accesses.
//  Drives PC/IF_ID write enables, bubble/flush strobes and a whole-pipe hold.
//  Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles in MEM_WAIT before timeout_o sets (>=1)
//  STALL_CNT_W     32   width of stall_cnt_o
// PORTS
//  clk_i             in   1   clock, rising edge
//  rst_i             in   1   reset, asynchronous, active-high
//  IF_ID_RS_i        in   5   rs of instruction in ID
//  IF_ID_RT_i        in   5   rt of instruction in ID
//  ID_branch_i       in   1   ID instruction is beq/bne (compares rs/rt in ID)
//  branch_taken_i    in   1   ID branch comparator result
//  ID_EX_MemRead_i   in   1   EX instruction is a load
//  ID_EX_RegWrite_i  in   1   EX instruction writes a register
//  ID_EX_RD_i        in   5   EX destination (rt for loads, post-mux)
//  EX_MEM_MemRead_i  in   1   MEM instruction is a load
//  EX_MEM_RD_i       in   5   MEM destination
//  dmem_req_i        in   1   MEM stage is accessing data memory this cycle
//  dmem_ready_i      in   1   data memory completes the access this cycle
//  PC_write_o        out  1   PC load enable
//  IF_ID_write_o     out  1   IF/ID load enable
//  IF_ID_flush_o     out  1   zero IF/ID at next edge
//  ID_EX_flush_o     out  1   load bubble into ID/EX (all control bits 0)
//  pipe_hold_o       out  1   freeze ID/EX and EX/MEM
//  MEM_WB_flush_o    out  1   load bubble into MEM/WB
//  stall_cnt_o       out  STALL_CNT_W  cycles with PC_write_o=0, saturating
//  timeout_o         out  1   sticky: a memory wait reached TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (rst_i=1, async):
//  - state=RUN, wait_cnt=0, stall_cnt_o=0, timeout_o=0.
//  - PC_write_o=0, IF_ID_write_o=0, IF_ID_flush_o=1, ID_EX_flush_o=1, pipe_hold_o=0, MEM_WB_flush_o=1.
//  Control outputs are combinational from state and inputs, so they act in the same cycle. Registers update on clk_i rise.
//  Hazard terms (register 0 never matches):
//  - lu_haz: ID_EX_MemRead_i && RD==IF_ID_RS_i|RT_i.
//  - br_ex: ID_branch_i && ID_EX_RegWrite_i && ID_EX_RD_i==RS|RT.
//  - br_mem: ID_branch_i && EX_MEM_MemRead_i && EX_MEM_RD_i==RS|RT.
//  - id_stall = lu_haz|br_ex|br_mem.
//  - mem_stall = dmem_req_i && !dmem_ready_i.
//  FSM states RUN, MEM_WAIT.
//  - RUN with mem_stall: outputs are pipe_hold=1, PC_write=0, IF_ID_write=0, MEM_WB_flush=1; ID_EX_flush=0, IF_ID_flush=0. Next state is MEM_WAIT with wait_cnt=1.
//  - RUN with id_stall and no mem_stall: PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0. This is a 1-cycle bubble, re-evaluated every cycle. Load-then-branch therefore stalls 2 cycles.
//  - RUN with neither: PC_write=1, IF_ID_write=1, IF_ID_flush=ID_branch_i&&branch_taken_i.
//  - MEM_WAIT: outputs same as the RUN+mem_stall case. wait_cnt increments; timeout_o sets when wait_cnt==TIMEOUT_CYCLES. The pipeline stays frozen after timeout. dmem_ready_i=1 releases the freeze that cycle; MEM_WB captures, and next state is RUN.
//  Priority: mem_stall/MEM_WAIT > id_stall > branch flush. A taken branch with id_stall never flushes; it is re-evaluated after the stall.
//  dmem_ready_i without dmem_req_i is ignored.
//  stall_cnt_o +1 per cycle with PC_write_o=0 while not in reset; saturates at all-ones.
//  Reset during MEM_WAIT aborts to RUN, and wait_cnt clears.
// STRUCTURE
//  hazard_pkg: state enum {RUN, MEM_WAIT}, REG_ZERO=5'd0, default TIMEOUT_CYCLES.
//  Sub-module sat_counter (WIDTH, inc_i, clr_i, cnt_o) is used for both stall_cnt_o and wait_cnt.
//  Hazard compares stay in-line.
// TESTING
//  1. Load-use: ID_EX_MemRead=1, RD=5, IF_ID_RS=5 -> 1 cycle PC_write=0, ID_EX_flush=1; stall_cnt 0->1.
//  2. Load then beq on $7: cycle1 br_ex stall, cycle2 br_mem stall, cycle3 PC_write=1, IF_ID_flush=branch_taken.
//  3. RD=0 with MemRead=1 and RS=0 -> no stall; taken branch alone -> IF_ID_flush=1 for 1 cycle.
//  4. dmem_req=1, ready low 4 cycles -> pipe_hold=1, MEM_WB_flush=1 for 4 cycles, released the cycle ready=1; stall_cnt +=4.
//  5. TIMEOUT_CYCLES=8, ready held low 20 cycles -> timeout_o=1 from the 8th wait cycle, sticky past release until rst_i.
//  6. rst_i pulsed mid-MEM_WAIT with load-use pending -> immediate reset outputs; state RUN, counters 0 on release.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard control unit.
package hazard_pkg;

    // Control-unit FSM: RUN issues normally, MEM_WAIT holds the pipe for data memory.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Register $0 is hard-wired to zero and never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default number of memory-wait cycles before the timeout flag sets.
    localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;

    // Clear wins over increment; increment stops once the counter is full.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush control for the 5-stage MIPS pipeline: load-use, ID-stage
// branch operand, and multi-cycle data-memory hazards.
//
// Handshake: a data-memory access is in flight while dmem_req_i=1; it
// completes in the cycle dmem_ready_i=1. While in MEM_WAIT the access is
// assumed to be held, so dmem_ready_i alone releases the freeze. In RUN,
// dmem_ready_i without dmem_req_i has no effect.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int STALL_CNT_W    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [4:0]             IF_ID_RS_i,
    input  logic [4:0]             IF_ID_RT_i,
    input  logic                   ID_branch_i,
    input  logic                   branch_taken_i,
    input  logic                   ID_EX_MemRead_i,
    input  logic                   ID_EX_RegWrite_i,
    input  logic [4:0]             ID_EX_RD_i,
    input  logic                   EX_MEM_MemRead_i,
    input  logic [4:0]             EX_MEM_RD_i,
    input  logic                   dmem_req_i,
    input  logic                   dmem_ready_i,
    output logic                   PC_write_o,
    output logic                   IF_ID_write_o,
    output logic                   IF_ID_flush_o,
    output logic                   ID_EX_flush_o,
    output logic                   pipe_hold_o,
    output logic                   MEM_WB_flush_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   timeout_o,
    output logic                   state_dbg_o
);

    // Wait counter must hold TIMEOUT_CYCLES; keep at least 2 bits for the counter.
    localparam int WAIT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WAIT_W     = (WAIT_W_RAW < 2) ? 2 : WAIT_W_RAW;
    // Timeout fires on the edge where the wait count reaches TIMEOUT_CYCLES.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_timeout;
    logic [WAIT_W-1:0] w_wait_cnt;

    logic w_lu_haz;
    logic w_br_ex;
    logic w_br_mem;
    logic w_id_stall;
    logic w_mem_stall;
    logic w_frozen;
    logic w_stall_inc;

    // Load in EX feeding the instruction in ID: one bubble needed.
    assign w_lu_haz = ID_EX_MemRead_i && (ID_EX_RD_i != REG_ZERO) &&
                      ((ID_EX_RD_i == IF_ID_RS_i) || (ID_EX_RD_i == IF_ID_RT_i));

    // Branch compares in ID, so any in-flight EX result it reads is not ready yet.
    assign w_br_ex = ID_branch_i && ID_EX_RegWrite_i && (ID_EX_RD_i != REG_ZERO) &&
                     ((ID_EX_RD_i == IF_ID_RS_i) || (ID_EX_RD_i == IF_ID_RT_i));

    // A load in MEM is still not forwardable into the ID comparator.
    assign w_br_mem = ID_branch_i && EX_MEM_MemRead_i && (EX_MEM_RD_i != REG_ZERO) &&
                      ((EX_MEM_RD_i == IF_ID_RS_i) || (EX_MEM_RD_i == IF_ID_RT_i));

    assign w_id_stall  = w_lu_haz || w_br_ex || w_br_mem;
    assign w_mem_stall = dmem_req_i && !dmem_ready_i;

    // The whole pipe is frozen on a new unfinished access or an ongoing wait.
    assign w_frozen = (r_state == MEM_WAIT) ? !dmem_ready_i : w_mem_stall;

    // Same-cycle control outputs; memory freeze beats ID stall beats branch flush.
    always_comb begin
        PC_write_o     = 1'b1;
        IF_ID_write_o  = 1'b1;
        IF_ID_flush_o  = ID_branch_i && branch_taken_i;
        ID_EX_flush_o  = 1'b0;
        pipe_hold_o    = 1'b0;
        MEM_WB_flush_o = 1'b0;
        if (rst_i) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            IF_ID_flush_o  = 1'b1;
            ID_EX_flush_o  = 1'b1;
            MEM_WB_flush_o = 1'b1;
        end else if (w_frozen) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            IF_ID_flush_o  = 1'b0;
            pipe_hold_o    = 1'b1;
            MEM_WB_flush_o = 1'b1;
        end else if (w_id_stall) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            IF_ID_flush_o  = 1'b0;
            ID_EX_flush_o  = 1'b1;
        end
    end

    // FSM and sticky timeout: stay in MEM_WAIT while frozen, latch timeout at the limit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= RUN;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_frozen ? MEM_WAIT : RUN;
            if (w_frozen && (w_wait_cnt == WAIT_LAST)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Counts frozen cycles; clears whenever the pipe is released.
    sat_counter #(
        .WIDTH (WAIT_W)
    ) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_frozen),
        .clr_i (!w_frozen),
        .cnt_o (w_wait_cnt)
    );

    assign w_stall_inc = !PC_write_o && !rst_i;

    // Counts every cycle the PC is held, for performance monitoring.
    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (w_stall_inc),
        .clr_i (1'b0),
        .cnt_o (stall_cnt_o)
    );

    assign timeout_o   = r_timeout;
    assign state_dbg_o = (r_state == MEM_WAIT);

endmodule
